// File: rtl/lab2_serial_adder.sv
// lab2_serial_adder: bit-serial ripple adder (one full-adder cell plus a carry flop).
// Operands are processed LSB first, one bit per clock. The result is presented with
// a one-cycle done pulse. The result and carry-out then hold until the next accepted start.
// Optional feature macro: SERIAL_SUB_MODE_EN adds a 'sub' input for subtraction.
// In subtract mode, cout reports the borrow-out.
module lab2_serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_SUB_MODE_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Majority of three: the carry output of a full-adder cell.
    function automatic logic fa_carry(input logic x, input logic y, input logic c);
        return (x & y) | (x & c) | (y & c);
    endfunction

    // Sum output of a full-adder cell (three-input parity).
    function automatic logic fa_sum(input logic x, input logic y, input logic c);
        return x ^ y ^ c;
    endfunction

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             sub_start_s;
    logic             sub_run_s;
    logic             bit_s;
    logic             carry_next_s;

`ifdef SERIAL_SUB_MODE_EN
    logic sub_q, sub_d;

    // Subtract-mode flag, captured with the operands when a start is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_q <= 1'b0;
        end else begin
            sub_q <= sub_d;
        end
    end

    // Subtract mode is selected while idle and then held for the whole operation.
    always_comb begin
        sub_start_s = sub;
        sub_run_s   = sub_q;
        sub_d       = sub_q;
        if ((state_q == ST_IDLE) && start) begin
            sub_d = sub;
        end else begin
            sub_d = sub_q;
        end
    end
`else
    // Add-only build: subtract mode is permanently off.
    always_comb begin
        sub_start_s = 1'b0;
        sub_run_s   = 1'b0;
    end
`endif

    // Full-adder cell that operates on the current LSBs and the stored carry.
    always_comb begin
        bit_s        = fa_sum(a_q[0], b_q[0], carry_q);
        carry_next_s = fa_carry(a_q[0], b_q[0], carry_q);
    end

    // Next-state and datapath control for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Subtraction is a + ~b + ~cin. The carry is inverted at the end to form the borrow.
                    a_d     = a;
                    b_d     = sub_start_s ? ~b : b;
                    carry_d = sub_start_s ? ~cin : cin;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                carry_d = carry_next_s;
                sum_d   = {bit_s, sum_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                if (cnt_q == LAST_BIT) begin
                    cout_d  = sub_run_s ? ~carry_next_s : carry_next_s;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, shift registers, carry flop and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_lab2_serial_adder.sv
// Self-checking bench for lab2_serial_adder (WIDTH=4). The reference result is plain integer
// arithmetic on the operands. Build with +define+SERIAL_SUB_MODE_EN to cover subtract mode.
module tb_lab2_serial_adder;

    localparam int W = 4;
    localparam int MAXC = 40;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub_s;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int tests_run;
    int tests_failed;

    lab2_serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_SUB_MODE_EN
        .sub   (sub_s),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {cout,sum} = a+b+cin. In subtract mode, the sum is a-b-cin mod 16 and cout is the borrow.
    function automatic logic [W:0] ref_model(input int av, input int bv, input int cv, input int sv);
        int r;
        if (sv != 0) begin
            r = av - bv - cv;
            return {(r < 0) ? 1'b1 : 1'b0, W'((r + 64) % 16)};
        end else begin
            r = av + bv + cv;
            return (W + 1)'(r);
        end
    endfunction

    // Drive one operation from IDLE. Operands are scrambled after the start edge.
    // The task returns at the falling edge of the cycle in which done is high.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                         input logic sv, output int cycles, output logic timed_out);
        @(negedge clk);
        start = 1'b1; a = av; b = bv; cin = cv; sub_s = sv;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub_s = 1'($urandom);
        cycles = 0;
        timed_out = 1'b1;
        for (int i = 0; i < MAXC; i++) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (done === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub_s = 1'b0;
        #2;
        tests_run++;
        if ({busy, done, cout, sum} !== {3'b000, 4'h0}) begin
            tests_failed++;
            $display("FAIL reset_state: busy=%b done=%b cout=%b sum=%0d, required all 0", busy, done, cout, sum);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_add();
        int cyc; logic to;
        do_op(4'd3, 4'd5, 1'b0, 1'b0, cyc, to);
        tests_run++;
        if (to || cyc != W) begin
            tests_failed++;
            $display("FAIL latency: timeout=%b cycles=%0d, required %0d", to, cyc, W);
        end
        tests_run++;
        if ({cout, sum} !== 5'd8) begin
            tests_failed++;
            $display("FAIL add_3_5: cout=%b sum=%0d, required cout=0 sum=8", cout, sum);
        end
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_in_done: busy=%b, required 1", busy);
        end
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL after_done: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_overflow_hold();
        int cyc; logic to;
        do_op(4'd15, 4'd1, 1'b0, 1'b0, cyc, to);
        tests_run++;
        if (to || {cout, sum} !== 5'b10000) begin
            tests_failed++;
            $display("FAIL add_15_1: timeout=%b cout=%b sum=%0d, required cout=1 sum=0", to, cout, sum);
        end
        @(negedge clk);
        do_op(4'd7, 4'd8, 1'b1, 1'b0, cyc, to);
        tests_run++;
        if (to || {cout, sum} !== 5'b10000) begin
            tests_failed++;
            $display("FAIL add_7_8_1: timeout=%b cout=%b sum=%0d, required cout=1 sum=0", to, cout, sum);
        end
        repeat (5) @(negedge clk);
        tests_run++;
        if ({cout, sum} !== 5'b10000 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold: cout=%b sum=%0d done=%b, required cout=1 sum=0 done=0", cout, sum, done);
        end
    endtask

    task automatic test_busy_ignore();
        int cyc; logic to;
        @(negedge clk);
        start = 1'b1; a = 4'd9; b = 4'd4; cin = 1'b0; sub_s = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; a = 4'd0; b = 4'd0; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc = 2;
        to = 1'b1;
        for (int i = 0; i < MAXC; i++) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) begin
                to = 1'b0;
                break;
            end
        end
        tests_run++;
        if (to || cyc != W || {cout, sum} !== 5'd13) begin
            tests_failed++;
            $display("FAIL ignore_start: timeout=%b cycles=%0d cout=%b sum=%0d, required cycles=4 cout=0 sum=13",
                     to, cyc, cout, sum);
        end
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_after_ignore: busy=%b, required 0", busy);
        end
        do_op(4'd6, 4'd6, 1'b1, 1'b0, cyc, to);
        tests_run++;
        if (to || {cout, sum} !== 5'd13) begin
            tests_failed++;
            $display("FAIL next_start: timeout=%b cout=%b sum=%0d, required cout=0 sum=13", to, cout, sum);
        end
    endtask

    task automatic test_async_reset();
        int cyc; logic to; logic seen_done;
        @(negedge clk);
        start = 1'b1; a = 4'd11; b = 4'd7; cin = 1'b1; sub_s = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({busy, done, cout, sum} !== {3'b000, 4'h0}) begin
            tests_failed++;
            $display("FAIL async_reset: busy=%b done=%b cout=%b sum=%0d, required all 0", busy, done, cout, sum);
        end
        seen_done = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (done === 1'b1) seen_done = 1'b1;
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (done === 1'b1) seen_done = 1'b1;
        end
        tests_run++;
        if (seen_done !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_no_done: done_seen=%b busy=%b, required 0 0", seen_done, busy);
        end
        do_op(4'd11, 4'd7, 1'b1, 1'b0, cyc, to);
        tests_run++;
        if (to || {cout, sum} !== ref_model(11, 7, 1, 0)) begin
            tests_failed++;
            $display("FAIL after_reset_op: timeout=%b cout=%b sum=%0d, required cout=1 sum=3", to, cout, sum);
        end
        @(negedge clk);
    endtask

`ifdef SERIAL_SUB_MODE_EN
    task automatic test_sub_mode();
        int cyc; logic to;
        logic [W:0] req [3];
        int ops [3][3];
        ops[0][0] = 5; ops[0][1] = 3; ops[0][2] = 0; req[0] = 5'b00010;
        ops[1][0] = 3; ops[1][1] = 5; ops[1][2] = 0; req[1] = 5'b11110;
        ops[2][0] = 0; ops[2][1] = 0; ops[2][2] = 1; req[2] = 5'b11111;
        for (int k = 0; k < 3; k++) begin
            do_op(W'(ops[k][0]), W'(ops[k][1]), 1'(ops[k][2]), 1'b1, cyc, to);
            tests_run++;
            if (to || {cout, sum} !== req[k]) begin
                tests_failed++;
                $display("FAIL sub_%0d: timeout=%b cout=%b sum=%0d, required cout=%b sum=%0d",
                         k, to, cout, sum, req[k][W], req[k][W-1:0]);
            end
            @(negedge clk);
        end
    endtask
`endif

    task automatic test_sweep();
        int cyc; logic to; int nsub; logic [W:0] exp_v;
`ifdef SERIAL_SUB_MODE_EN
        nsub = 2;
`else
        nsub = 1;
`endif
        for (int sv = 0; sv < nsub; sv++)
            for (int av = 0; av < 16; av++)
                for (int bv = 0; bv < 16; bv++)
                    for (int cv = 0; cv < 2; cv++) begin
                        do_op(W'(av), W'(bv), 1'(cv), 1'(sv), cyc, to);
                        exp_v = ref_model(av, bv, cv, sv);
                        tests_run++;
                        if (to || cyc != W || {cout, sum} !== exp_v) begin
                            tests_failed++;
                            $display("FAIL sweep a=%0d b=%0d cin=%0d sub=%0d: timeout=%b cycles=%0d cout=%b sum=%0d, required cout=%b sum=%0d",
                                     av, bv, cv, sv, to, cyc, cout, sum, exp_v[W], exp_v[W-1:0]);
                        end
                        @(negedge clk);
                    end
    endtask

    task automatic test_back_to_back();
        int cyc; logic to; logic [W:0] exp_v;
        logic [W-1:0] av, bv; logic cv, sv;
        for (int k = 0; k < 40; k++) begin
            av = W'($urandom); bv = W'($urandom); cv = 1'($urandom);
`ifdef SERIAL_SUB_MODE_EN
            sv = 1'($urandom);
`else
            sv = 1'b0;
`endif
            do_op(av, bv, cv, sv, cyc, to);
            exp_v = ref_model(int'(av), int'(bv), int'(cv), int'(sv));
            tests_run++;
            if (to || {cout, sum} !== exp_v) begin
                tests_failed++;
                $display("FAIL b2b a=%0d b=%0d cin=%0d sub=%0d: timeout=%b cout=%b sum=%0d, required cout=%b sum=%0d",
                         av, bv, cv, sv, to, cout, sum, exp_v[W], exp_v[W-1:0]);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_basic_add();
        test_overflow_hold();
        test_busy_ignore();
        test_async_reset();
`ifdef SERIAL_SUB_MODE_EN
        test_sub_mode();
`endif
        test_sweep();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
